// File: rtl/sprite_blit_ctrl.sv
// rtl/sprite_blit_ctrl.sv - sequences a registered sprite ROM into clipped framebuffer writes
//
// Purpose: on i_start, walks every ROM pixel in raster order and writes it to
// the framebuffer at (dst_x+col, dst_y+row), skipping off-screen pixels and
// (optionally) transparent ones.
//
// Ports:
//   i_clk        system clock, all logic on posedge
//   i_reset      asynchronous active-high reset
//   i_start      begin a blit (sampled only in IDLE)
//   i_dst_x/y    sprite top-left, latched at start
//   o_busy       high while a blit is in progress
//   o_done       one-cycle pulse when the blit completes
//   o_rom_row/col  registered ROM address
//   i_rom_data   ROM color, valid one cycle after the address
//   o_fb_we/x/y/data  registered framebuffer write request
//   i_fb_ready   framebuffer accepts the write when o_fb_we && i_fb_ready
module sprite_blit_ctrl #(
    parameter int          IMG_W       = 584,
    parameter int          IMG_H       = 167,
    parameter int          ROW_W       = 8,
    parameter int          COL_W       = 10,
    parameter int          FB_W        = 640,
    parameter int          FB_H        = 480,
    parameter int          XW          = 10,
    parameter int          YW          = 9,
    parameter logic [11:0] TRANSP      = 12'h000,
    parameter bit          SKIP_TRANSP = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [XW-1:0]    i_dst_x,
    input  logic [YW-1:0]    i_dst_y,
    output logic             o_busy,
    output logic             o_done,
    output logic [ROW_W-1:0] o_rom_row,
    output logic [COL_W-1:0] o_rom_col,
    input  logic [11:0]      i_rom_data,
    output logic             o_fb_we,
    output logic [XW-1:0]    o_fb_x,
    output logic [YW-1:0]    o_fb_y,
    output logic [11:0]      o_fb_data,
    input  logic             i_fb_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_WRITE,
        S_NEXT,
        S_DONE
    } state_t;

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - 1);
    localparam logic [XW:0]      FB_W_L   = (XW + 1)'(FB_W);
    localparam logic [YW:0]      FB_H_L   = (YW + 1)'(FB_H);

    state_t           r_state;
    state_t           w_next;

    logic [XW-1:0]    r_dst_x;
    logic [YW-1:0]    r_dst_y;
    // Row/col counters double as the registered ROM address.
    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_col;
    logic             r_fb_we;
    logic [XW-1:0]    r_fb_x;
    logic [YW-1:0]    r_fb_y;
    logic [11:0]      r_fb_data;

    // One extra bit so coordinates past the screen edge are seen, not wrapped.
    logic [XW:0]      w_x;
    logic [YW:0]      w_y;
    logic             w_skip;
    logic             w_last_col;
    logic             w_last_row;

    assign w_x        = {1'b0, r_dst_x} + (XW + 1)'(r_col);
    assign w_y        = {1'b0, r_dst_y} + (YW + 1)'(r_row);
    assign w_skip     = (w_x >= FB_W_L) || (w_y >= FB_H_L) ||
                        (SKIP_TRANSP && (i_rom_data == TRANSP));
    assign w_last_col = (r_col == LAST_COL);
    assign w_last_row = (r_row == LAST_ROW);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (i_start) w_next = S_ISSUE;
            S_ISSUE:   w_next = S_CAPTURE;
            S_CAPTURE: w_next = w_skip ? S_NEXT : S_WRITE;
            S_WRITE:   if (i_fb_ready) w_next = S_NEXT;
            S_NEXT:    w_next = (w_last_col && w_last_row) ? S_DONE : S_ISSUE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_dst_x   <= '0;
            r_dst_y   <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_fb_we   <= 1'b0;
            r_fb_x    <= '0;
            r_fb_y    <= '0;
            r_fb_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_dst_x <= i_dst_x;
                        r_dst_y <= i_dst_y;
                        r_row   <= '0;
                        r_col   <= '0;
                    end
                end
                S_CAPTURE: begin
                    r_fb_data <= i_rom_data;
                    if (!w_skip) begin
                        r_fb_x  <= w_x[XW-1:0];
                        r_fb_y  <= w_y[YW-1:0];
                        r_fb_we <= 1'b1;
                    end
                end
                S_WRITE: begin
                    if (i_fb_ready) r_fb_we <= 1'b0;
                end
                S_NEXT: begin
                    // On the final pixel both counters wrap to 0, keeping the
                    // address inside the image while idle.
                    if (w_last_col) begin
                        r_col <= '0;
                        r_row <= w_last_row ? '0 : r_row + 1'b1;
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy    = (r_state != S_IDLE) && (r_state != S_DONE);
    assign o_done    = (r_state == S_DONE);
    assign o_rom_row = r_row;
    assign o_rom_col = r_col;
    assign o_fb_we   = r_fb_we;
    assign o_fb_x    = r_fb_x;
    assign o_fb_y    = r_fb_y;
    assign o_fb_data = r_fb_data;

endmodule
